// File: rtl/wyswietlanie_rpm_wielocyfrowe.sv
// Multiplexed N-digit 7-segment rpm display driver.
// A sequential double-dabble engine converts the binary rpm value to BCD before it is shown.
module wyswietlanie_rpm_wielocyfrowe #(
  parameter int RPM_W       = 7,
  parameter int N_DIGITS    = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RPM_W-1:0]    rpm,
  input  logic                rpm_valid,
  output logic                busy,
  output logic [7:0]          seven_segmented_display,
  output logic [N_DIGITS-1:0] zalaczony_wyswietlacz
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(RPM_W + 1);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [31:0]         MAX_VAL  = 32'(10 ** N_DIGITS - 1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(RPM_W - 1);
  localparam logic [PW-1:0]       PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]       DIG_LAST = DW'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_POL  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] EN_POL   = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [7:0]          SEG_RST  = 8'h3F ^ SEG_POL;
  localparam logic [N_DIGITS-1:0] EN_RST   = N_DIGITS'(1) ^ EN_POL;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [RPM_W-1:0]    bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [BW-1:0]       disp_bcd_q, disp_bcd_d;
  logic                disp_ovf_q, disp_ovf_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [7:0]          seg_q, seg_d, seg_raw, seg_k;
  logic [N_DIGITS-1:0] en_q, en_d;
  logic [3:0]          nib;
  logic                hi_zero;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 8'h3F;
      4'd1: seg7 = 8'h06;
      4'd2: seg7 = 8'h5B;
      4'd3: seg7 = 8'h4F;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'h6D;
      4'd6: seg7 = 8'h7D;
      4'd7: seg7 = 8'h07;
      4'd8: seg7 = 8'h7F;
      4'd9: seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                             : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    disp_bcd_d = disp_bcd_q;
    disp_ovf_d = disp_ovf_q;
    case (state_q)
      IDLE: begin
        if (rpm_valid) begin
          bin_d   = rpm;
          ovf_d   = (32'(rpm) > MAX_VAL);
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = COMMIT;
      end
      COMMIT: begin
        disp_bcd_d = bcd_q;
        disp_ovf_d = ovf_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    dig_d = dig_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
  end

  // Decode from the next-cycle display value so a commit and the outputs land on the same edge.
  always_comb begin
    hi_zero = 1'b1;
    seg_raw = 8'h00;
    nib     = 4'd0;
    seg_k   = 8'h00;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nib     = disp_bcd_d[4*k +: 4];
      hi_zero = hi_zero & (nib == 4'd0);
      if (disp_ovf_d)
        seg_k = 8'h40;
      else if ((BLANK_LZ != 0) && (k > 0) && hi_zero)
        seg_k = 8'h00;
      else
        seg_k = seg7(nib);
      if (DW'(k) == dig_d) seg_raw = seg_k;
    end
    seg_d = seg_raw ^ SEG_POL;
    en_d  = (N_DIGITS'(1) << dig_d) ^ EN_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
      pre_q      <= '0;
      dig_q      <= '0;
      seg_q      <= SEG_RST;
      en_q       <= EN_RST;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
      pre_q      <= pre_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      en_q       <= en_d;
    end
  end

  assign busy                    = (state_q != IDLE);
  assign seven_segmented_display = seg_q;
  assign zalaczony_wyswietlacz   = en_q;

endmodule

// File: tb/tb_wyswietlanie_rpm_wielocyfrowe.sv
// Directed bench for the multi-digit rpm display: vector table plus multi-cycle sequences.
// A second instance with inverted polarity runs in lockstep and must mirror the first bitwise.
module tb_wyswietlanie_rpm_wielocyfrowe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] rpm = '0;
  logic       rpm_valid = 1'b0;
  logic       busy, busy_n;
  logic [7:0] seg, seg_n;
  logic [1:0] en, en_n;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0] v;
    logic [7:0] s0;
    logic [7:0] s1;
  } vec_t;

  vec_t vecs[10];

  wyswietlanie_rpm_wielocyfrowe #(
    .RPM_W(7), .N_DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rpm(rpm), .rpm_valid(rpm_valid), .busy(busy),
    .seven_segmented_display(seg), .zalaczony_wyswietlacz(en)
  );

  wyswietlanie_rpm_wielocyfrowe #(
    .RPM_W(7), .N_DIGITS(2), .REFRESH_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .rpm(rpm), .rpm_valid(rpm_valid), .busy(busy_n),
    .seven_segmented_display(seg_n), .zalaczony_wyswietlacz(en_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] s_exp, input logic [1:0] e_exp);
    logic [7:0] si;
    logic [1:0] ei;
    si = ~s_exp;
    ei = ~e_exp;
    chk({name, " seg"}, 32'(seg), 32'(s_exp));
    chk({name, " en"}, 32'(en), 32'(e_exp));
    chk({name, " seg_inv"}, 32'(seg_n), 32'(si));
    chk({name, " en_inv"}, 32'(en_n), 32'(ei));
    $display("t=%0t %s: en=%b seg=%h en_inv=%b seg_inv=%h", $time, name, en, seg, en_n, seg_n);
  endtask

  task automatic wait_show(input string name, input logic [1:0] target, input logic [7:0] s_exp);
    int i;
    i = 0;
    while (en !== target && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk_out(name, s_exp, target);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk({name, " busy done"}, 32'(busy), 32'd0);
  endtask

  task automatic load(input logic [6:0] v);
    @(negedge clk);
    rpm       = v;
    rpm_valid = 1'b1;
    @(negedge clk);
    rpm_valid = 1'b0;
    wait_idle($sformatf("load %0d", v));
  endtask

  initial begin
    vecs[0] = '{7'd7,   8'h07, 8'h00};
    vecs[1] = '{7'd0,   8'h3F, 8'h00};
    vecs[2] = '{7'd100, 8'h40, 8'h40};
    vecs[3] = '{7'd99,  8'h6F, 8'h6F};
    vecs[4] = '{7'd10,  8'h3F, 8'h06};
    vecs[5] = '{7'd50,  8'h3F, 8'h6D};
    vecs[6] = '{7'd127, 8'h40, 8'h40};
    vecs[7] = '{7'd9,   8'h6F, 8'h00};
    vecs[8] = '{7'd42,  8'h5B, 8'h66};
    vecs[9] = '{7'd81,  8'h06, 8'h7F};

    // Reset state
    repeat (2) @(negedge clk);
    chk_out("reset", 8'h3F, 2'b01);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset busy_inv", 32'(busy_n), 32'd0);

    // Refresh with no load: each digit enabled for 4 clocks, digit1 blanked
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (((k / 4) % 2) == 0) chk_out($sformatf("refresh k=%0d", k), 8'h3F, 2'b01);
      else                    chk_out($sformatf("refresh k=%0d", k), 8'h00, 2'b10);
      @(negedge clk);
    end

    // Busy timing for a single-cycle strobe of 65
    @(negedge clk);
    rpm       = 7'd65;
    rpm_valid = 1'b1;
    @(negedge clk);
    rpm_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("busy cycle %0d", i + 1), 32'(busy), 32'd1);
      chk($sformatf("busy_inv cycle %0d", i + 1), 32'(busy_n), 32'd1);
      @(negedge clk);
    end
    chk("busy after commit", 32'(busy), 32'd0);
    wait_show("rpm65 d0", 2'b01, 8'h6D);
    wait_show("rpm65 d1", 2'b10, 8'h7D);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].v);
      wait_show($sformatf("rpm%0d d0", vecs[i].v), 2'b01, vecs[i].s0);
      wait_show($sformatf("rpm%0d d1", vecs[i].v), 2'b10, vecs[i].s1);
    end

    // Second request while busy is dropped
    @(negedge clk);
    rpm       = 7'd65;
    rpm_valid = 1'b1;
    @(negedge clk);
    rpm       = 7'd12;
    rpm_valid = 1'b1;
    @(negedge clk);
    rpm_valid = 1'b0;
    wait_idle("drop");
    repeat (2) @(negedge clk);
    chk("drop no reload busy", 32'(busy), 32'd0);
    wait_show("drop d0", 2'b01, 8'h6D);
    wait_show("drop d1", 2'b10, 8'h7D);

    // Reset in the middle of a conversion
    load(7'd99);
    @(negedge clk);
    rpm       = 7'd65;
    rpm_valid = 1'b1;
    @(negedge clk);
    rpm_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 8'h3F, 2'b01);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset busy_inv", 32'(busy_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post reset busy", 32'(busy), 32'd0);
    wait_show("post reset d0", 2'b01, 8'h3F);
    wait_show("post reset d1", 2'b10, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
